// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
//   Parallel-word handshake bundle between a data source and the UART
//   frame transmitter.
//   XMT_REQ  : source -> tx, request a frame; XMT_DATA valid while high
//   XMT_DATA : source -> tx, word to send (sampled on frame start only)
//   XMT_ACK  : tx -> source, frame complete acknowledge
//   XMT      : tx -> pin, serial line (idle high)
//   BUSY     : tx -> source, frame in progress / handshake open
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 XMT_REQ;
  logic [DATA_BITS-1:0] XMT_DATA;
  logic                 XMT_ACK;
  logic                 XMT;
  logic                 BUSY;

  modport master (
    output XMT_REQ,
    output XMT_DATA,
    input  XMT_ACK,
    input  XMT,
    input  BUSY
  );

  modport slave (
    input  XMT_REQ,
    input  XMT_DATA,
    output XMT_ACK,
    output XMT,
    output BUSY
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART serial transmitter: latches a parallel word on a four-phase
//   XMT_REQ/XMT_ACK handshake and shifts out start, data (LSB first),
//   optional parity and stop bits on XMT.
//   Parameters: DATA_BITS (5..9), CLKS_PER_BIT (>=2),
//               PARITY (0 none, 1 even, 2 odd), STOP_BITS (1 or 2)
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : handshake/serial bundle (slave side), see uart_tx_frame_if
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            clr_n,
  uart_tx_frame_if.slave  bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK
  } state_t;

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 xmt_q;
  logic                 ack_q;
  logic                 busy_q;
  logic                 baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // xmt_q is loaded with the level of the *next* bit on the boundary edge,
  // so the registered line changes only at bit boundaries.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      xmt_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          xmt_q  <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (bus.XMT_REQ) begin
            shift_q <= bus.XMT_DATA;
            par_q   <= (^bus.XMT_DATA) ^ 1'(PARITY == 2);
            xmt_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            xmt_q   <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                xmt_q   <= par_q;
                state_q <= S_PARITY;
              end else begin
                xmt_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              xmt_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            xmt_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          xmt_q <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              bit_q   <= '0;
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_ACK: begin
          xmt_q <= 1'b1;
          // REQ must be seen low before a new frame can be accepted.
          if (!bus.XMT_REQ) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          xmt_q   <= 1'b1;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.XMT     = xmt_q;
  assign bus.XMT_ACK = ack_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Four transmitter instances (8N1, 8E1, 8O1, 7N2; 4 clocks per bit).
//   Stimulus pushes the expected serial frame (bit k = line level of
//   frame bit k, k=0 is the start bit) into a per-instance queue; a monitor
//   per instance captures each frame from the line and compares.
module tb_uart_tx_frame;

  localparam int CPB  = 4;
  localparam int NDUT = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic       req    [NDUT];
  logic [8:0] din    [NDUT];
  logic       xmt_w  [NDUT];
  logic       ack_w  [NDUT];
  logic       busy_w [NDUT];

  logic [12:0] exp_q [NDUT][$];

  int checks = 0;
  int errors = 0;

  uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_tx_frame_if #(.DATA_BITS(8)) if_b ();
  uart_tx_frame_if #(.DATA_BITS(8)) if_c ();
  uart_tx_frame_if #(.DATA_BITS(7)) if_d ();

  assign if_a.XMT_REQ = req[0];  assign if_a.XMT_DATA = din[0][7:0];
  assign if_b.XMT_REQ = req[1];  assign if_b.XMT_DATA = din[1][7:0];
  assign if_c.XMT_REQ = req[2];  assign if_c.XMT_DATA = din[2][7:0];
  assign if_d.XMT_REQ = req[3];  assign if_d.XMT_DATA = din[3][6:0];

  assign xmt_w[0] = if_a.XMT;  assign ack_w[0] = if_a.XMT_ACK;  assign busy_w[0] = if_a.BUSY;
  assign xmt_w[1] = if_b.XMT;  assign ack_w[1] = if_b.XMT_ACK;  assign busy_w[1] = if_b.BUSY;
  assign xmt_w[2] = if_c.XMT;  assign ack_w[2] = if_c.XMT_ACK;  assign busy_w[2] = if_c.BUSY;
  assign xmt_w[3] = if_d.XMT;  assign ack_w[3] = if_d.XMT_ACK;  assign busy_w[3] = if_d.BUSY;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .clr_n(clr_n), .bus(if_a));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1))
    dut_b (.clk(clk), .clr_n(clr_n), .bus(if_b));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1))
    dut_c (.clk(clk), .clr_n(clr_n), .bus(if_c));
  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2))
    dut_d (.clk(clk), .clr_n(clr_n), .bus(if_d));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- monitors
  for (genvar g = 0; g < NDUT; g++) begin : g_mon
    localparam int NB = (g == 0 || g == 3) ? 10 : 11;
    initial begin
      logic        pb;
      logic [12:0] got;
      logic        steady;
      logic        aborted;
      pb = 1'b0;
      forever begin
        @(negedge clk);
        if (clr_n && busy_w[g] && !pb) begin
          got     = '0;
          steady  = 1'b1;
          aborted = 1'b0;
          for (int k = 0; k < NB && !aborted; k++) begin
            for (int c = 0; c < CPB && !aborted; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (!clr_n) aborted = 1'b1;
              else begin
                if (c == 0) got[k] = xmt_w[g];
                else if (xmt_w[g] !== got[k]) steady = 1'b0;
                if (busy_w[g] !== 1'b1 || ack_w[g] !== 1'b0) steady = 1'b0;
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            chk($sformatf("dut%0d ack_at_frame_end", g), {ack_w[g], xmt_w[g]}, 2'b11);
            chk($sformatf("dut%0d bits_steady", g), steady, 1);
            if (exp_q[g].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_frame: got 0x%0h expected none", g, got);
            end else begin
              chk($sformatf("dut%0d frame", g), got, exp_q[g].pop_front());
            end
          end
        end
        pb = busy_w[g];
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic raise(input int i, input logic [8:0] d, input logic [12:0] e);
    din[i] = d;
    req[i] = 1'b1;
    exp_q[i].push_back(e);
  endtask

  task automatic wait_ack(input int i);
    int n = 0;
    while (ack_w[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ack_w[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d ack_timeout: got ack=0 expected ack=1 within 200 cycles", i);
    end
  endtask

  task automatic finish_hs(input int i);
    req[i] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d ack_release", i), {ack_w[i], busy_w[i], xmt_w[i]}, 3'b001);
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < NDUT; i++) begin
      req[i] = 1'b0;
      din[i] = '0;
    end
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("dut%0d reset_state", i), {xmt_w[i], ack_w[i], busy_w[i]}, 3'b100);
    clr_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1 ; then REQ held 100 cycles
    raise(0, 9'h0A5, 13'b11_0100_1010);
    wait_ack(0);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if ({xmt_w[0], ack_w[0], busy_w[0]} !== 3'b111) ok = 1'b0;
    end
    chk("dut0 hold_req_high", ok, 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("dut0 idle_after_drop", {ack_w[0], busy_w[0], xmt_w[0]}, 3'b001);
    // 0x3C -> 0,0,0,1,1,1,1,0,0,1
    raise(0, 9'h03C, 13'b10_0111_1000);
    @(negedge clk);
    chk("dut0 restart_one_idle", {xmt_w[0], busy_w[0]}, 2'b01);
    wait_ack(0);
    finish_hs(0);

    // 8E1 0x07 -> parity 1 ; 0x00 -> parity 0
    raise(1, 9'h007, 13'b110_0000_1110);
    wait_ack(1);
    finish_hs(1);
    raise(1, 9'h000, 13'b100_0000_0000);
    wait_ack(1);
    finish_hs(1);

    // 8O1 0x00 -> parity 1 ; 0x07 -> parity 0
    raise(2, 9'h000, 13'b110_0000_0000);
    wait_ack(2);
    finish_hs(2);
    raise(2, 9'h007, 13'b100_0000_1110);
    wait_ack(2);
    finish_hs(2);

    // 7N2 0x55, data input changed mid-frame -> 0,1,0,1,0,1,0,1,1,1
    raise(3, 9'h055, 13'b11_1010_1010);
    repeat (5) @(negedge clk);
    din[3] = 9'h02A;
    wait_ack(3);
    finish_hs(3);

    // Asynchronous reset during data bit 3 of dut0 (frame discarded)
    din[0] = 9'h0F0;
    req[0] = 1'b1;
    repeat (18) @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("dut0 async_reset", {xmt_w[0], ack_w[0], busy_w[0]}, 3'b100);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if ({xmt_w[0], ack_w[0], busy_w[0]} !== 3'b100) ok = 1'b0;
    end
    chk("dut0 idle_after_reset", ok, 1);
    // 0x81 -> 0,1,0,0,0,0,0,0,1,1
    raise(0, 9'h081, 13'b11_0000_0010);
    wait_ack(0);
    finish_hs(0);

    // REQ dropped during data bits: 0xF0 -> 0,0,0,0,0,1,1,1,1,1
    raise(0, 9'h0F0, 13'b11_1110_0000);
    repeat (12) @(negedge clk);
    req[0] = 1'b0;
    wait_ack(0);
    @(negedge clk);
    chk("dut0 ack_one_cycle_pulse", {ack_w[0], busy_w[0], xmt_w[0]}, 3'b001);

    repeat (5) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("dut%0d frames_outstanding", i), exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
